nibbleadd_seq: RTL and testbench

//  Sequencer that sits directly upstream of nibbleadd and drives its A/B/ctrl inputs.
//  - Accepts one byte-operand pair per transaction over a valid/ready handshake.
//  - Runs the nibble adder twice: low nibbles (ctrl=0), then high nibbles (ctrl=1).
//  - Combines the two 5-bit partial sums into a full 9-bit byte sum.
//  - Presents the sum on a valid/ready output and counts completed transactions.

---
 rtl/nibbleadd_seq.sv | 93 +++++++++
 tb/tb_nibbleadd_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/nibbleadd_seq.sv
// nibbleadd_seq: drives an external nibble adder twice per operand pair
// (low nibbles, then high nibbles) and merges the two partial sums into a
// 9-bit byte sum presented on a valid/ready output.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for an operand pair, in_ready=1
//  LO    | adder sees low nibbles (add_ctrl=0), capture partial lo_r
//  HI    | adder sees high nibbles (add_ctrl=1), form {carry,sum}
//  DONE  | out_valid=1, sum/carry held until out_ready
module nibbleadd_seq #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   output logic [7:0]       add_a,
   output logic [7:0]       add_b,
   output logic             add_ctrl,
   input  logic [4:0]       add_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       sum,
   output logic             carry,
   output logic [CNT_W-1:0] txn_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state;
   logic [4:0] lo_r;

   // add_a/add_b double as the operand registers: they are loaded on accept
   // and held through IDLE/DONE, so the adder inputs never glitch mid-run.
   // Sequencer state, adder drive, result and transaction counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= 8'd0;
         carry     <= 1'b0;
         txn_cnt   <= '0;
         add_a     <= 8'd0;
         add_b     <= 8'd0;
         add_ctrl  <= 1'b0;
         lo_r      <= 5'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  add_a    <= in_a;
                  add_b    <= in_b;
                  add_ctrl <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= LO;
               end
            end
            LO: begin
               lo_r     <= add_q;
               add_ctrl <= 1'b1;
               state    <= HI;
            end
            HI: begin
               // high partial is weighted by 16; worst case 16*30+30 fits 9 bits
               {carry, sum} <= {add_q, 4'b0000} + {4'b0000, lo_r};
               out_valid    <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  txn_cnt   <= txn_cnt + CNT_W'(1);
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibbleadd_seq.sv
// tb_nibbleadd_seq: directed and random transactions through nibbleadd_seq,
// with a behavioural nibble adder on the add_* port and byte addition as the
// reference for every result.
module tb_nibbleadd_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_a = 8'd0;
   logic [7:0] in_b = 8'd0;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic       add_ctrl;
   logic [4:0] add_q;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] sum;
   logic       carry;
   logic [7:0] txn_cnt;

   int nerr = 0;
   int nchk = 0;
   int exp_cnt = 0;

   nibbleadd_seq #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_ctrl  (add_ctrl),
      .add_q     (add_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .txn_cnt   (txn_cnt)
   );

   // Stand-in for nibbleadd: plain sum of the selected nibbles.
   assign add_q = add_ctrl ? ({1'b0, add_a[7:4]} + {1'b0, add_b[7:4]})
                           : ({1'b0, add_a[3:0]} + {1'b0, add_b[3:0]});

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int hold);
      logic [8:0] full;
      full = {1'b0, a} + {1'b0, b};
      wait_ready();
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      step();
      in_valid = 1'b0;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      chk("lo_ctrl", 32'(add_ctrl), 32'd0);
      chk("lo_add_a", 32'(add_a), 32'(a));
      chk("lo_add_b", 32'(add_b), 32'(b));
      chk("lo_in_ready", 32'(in_ready), 32'd0);
      chk("lo_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("hi_ctrl", 32'(add_ctrl), 32'd1);
      chk("hi_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("done_out_valid", 32'(out_valid), 32'd1);
      chk("sum", 32'(sum), 32'(full[7:0]));
      chk("carry", 32'(carry), 32'(full[8]));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_a     = 8'($urandom);
         in_b     = 8'($urandom);
         step();
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_sum", 32'(sum), 32'(full[7:0]));
         chk("hold_carry", 32'(carry), 32'(full[8]));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      exp_cnt++;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("txn_cnt", 32'(txn_cnt), 32'(exp_cnt % 256));
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_carry", 32'(carry), 32'd0);
      chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
      chk("rst_add_a", 32'(add_a), 32'd0);
      chk("rst_add_ctrl", 32'(add_ctrl), 32'd0);
      rst_n = 1'b1;
      step();

      run_txn(8'h24, 8'h81, 0);
      run_txn(8'h0D, 8'h8D, 0);
      run_txn(8'hED, 8'h8C, 0);
      run_txn(8'hF9, 8'hC6, 0);
      run_txn(8'h3C, 8'hC4, 5);
      run_txn(8'hFF, 8'hFF, 0);
      run_txn(8'h00, 8'h00, 1);

      // abort a transaction while the high nibbles are on the adder
      wait_ready();
      in_valid = 1'b1;
      in_a     = 8'h77;
      in_b     = 8'h99;
      step();
      in_valid = 1'b0;
      step();
      chk("abort_in_hi", 32'(add_ctrl), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n   = 1'b1;
      exp_cnt = 0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_txn_cnt", 32'(txn_cnt), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_add_ctrl", 32'(add_ctrl), 32'd0);
      repeat (3) begin
         step();
         chk("abort_no_emit", 32'(out_valid), 32'd0);
      end

      run_txn(8'h01, 8'h0F, 0);

      // random pairs, enough to wrap the 8-bit counter
      for (int i = 0; i < 262; i++) begin
         run_txn(8'($urandom), 8'($urandom), (i % 17 == 3) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
